// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared types and address-field constants for the SDRAM
//                port arbiter and its burst tracker.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_pkg;

  localparam int COL_W   = 10;
  localparam int ROW_LSB = COL_W;
  localparam int ROW_MSB = 24;
  localparam int ADDR_W  = 25;
  localparam int ROW_W   = ROW_MSB - ROW_LSB + 1;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_BURST     = 3'd1,
    RD_BURST     = 3'd2,
    GAP          = 3'd3,
    REFRESH_WAIT = 3'd4
  } arb_state_t;

  // Which requester owns (or last owned) the controller port
  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } arb_grant_t;

  // Row field of a full SDRAM address
  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_burst_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_tracker
//  Description : Holds the open row and beat count of the current grant and
//                decides whether the presented beat may transfer and whether
//                the burst has to finish this cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_burst_tracker
  import sdram_pkg::*;
#(
  parameter int BURST_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,       // new grant this cycle
  input  logic [ROW_W-1:0] start_row,   // row of the granted request
  input  logic             beat_valid,  // granted requester has a beat
  input  logic [ROW_W-1:0] beat_row,    // row of the presented beat
  input  logic             ctrl_busy,
  input  logic             guard,
  output logic             ready,
  output logic             burst_end
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  logic [ROW_W-1:0] open_row;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             row_match;
  logic             below_max;
  logic             xfer;

  // Beat acceptance and burst termination, evaluated against the open row
  always_comb begin
    row_match = (beat_row == open_row);
    below_max = (beat_cnt < CNT_MAX);
    ready     = ~ctrl_busy & ~guard & row_match & below_max;
    xfer      = beat_valid & ready;
    cnt_next  = beat_cnt + {{(CNT_W-1){1'b0}}, xfer};
    // The final beat of a full burst transfers and ends the burst together
    burst_end = ~beat_valid | ~row_match | guard | (cnt_next == CNT_MAX);
  end

  // Open row latched on grant; count advances per transfer and saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_row <= '0;
      beat_cnt <= '0;
    end else if (start) begin
      open_row <= start_row;
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Shares the SDRAM controller command port between the camera
//                frame writer and the display frame reader. Grants row-bounded
//                bursts, stays clear of the refresh window, alternates between
//                requesters and lets an urgent display read jump the queue.
//                Optional statistics counters: define SDRAM_ARB_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int BURST_LEN     = 64,
  parameter int REFRESH_GUARD = 100
) (
  input  logic              ram_clk,
  input  logic              reset_n,
  // camera write path
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_mask,
  // display read path
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_urgent,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  // SDRAM controller
  input  logic              ctrl_busy,
  input  logic [DATA_W-1:0] ctrl_readData,
  input  logic              ctrl_readValid,
  input  logic [9:0]        refreshCountdown,
  output logic              write,
  output logic              isWrite,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        writeMask,
  output logic [DATA_W-1:0] writeData,
  output logic              keepOpen
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_wr_beats,
  output logic [31:0]       stat_rd_beats,
  output logic [31:0]       stat_refresh_stalls
`endif
);

  localparam logic [9:0] GUARD_VAL = 10'(REFRESH_GUARD);

  arb_state_t        state;
  arb_state_t        next_state;
  arb_grant_t        last_grant;
  arb_grant_t        grant_to;
  logic              grant_start;
  logic [ROW_W-1:0]  grant_row;
  logic              guard;
  logic              in_wr;
  logic              in_rd;
  logic              beat_valid;
  logic [ADDR_W-1:0] beat_addr;
  logic              trk_ready;
  logic              trk_end;

  // Refresh window and burst-state decode
  always_comb begin
    guard      = (refreshCountdown <= GUARD_VAL);
    in_wr      = (state == WR_BURST);
    in_rd      = (state == RD_BURST);
    beat_valid = (in_wr & wr_valid) | (in_rd & rd_valid);
    beat_addr  = in_wr ? wr_addr : (in_rd ? rd_addr : '0);
  end

  sdram_burst_tracker #(
    .BURST_LEN (BURST_LEN)
  ) u_tracker (
    .clk        (ram_clk),
    .rst_n      (reset_n),
    .start      (grant_start),
    .start_row  (grant_row),
    .beat_valid (beat_valid),
    .beat_row   (row_of(beat_addr)),
    .ctrl_busy  (ctrl_busy),
    .guard      (guard),
    .ready      (trk_ready),
    .burst_end  (trk_end)
  );

  // State and fairness register
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_RD;
    end else begin
      state <= next_state;
      if (grant_start) begin
        last_grant <= grant_to;
      end
    end
  end

  // Arbitration and burst sequencing
  always_comb begin
    next_state  = state;
    grant_start = 1'b0;
    grant_to    = last_grant;
    case (state)
      IDLE: begin
        if (guard) begin
          next_state = REFRESH_WAIT;
        end else if (rd_valid & rd_urgent) begin
          next_state  = RD_BURST;
          grant_start = 1'b1;
          grant_to    = GRANT_RD;
        end else if (wr_valid & rd_valid) begin
          grant_start = 1'b1;
          if (last_grant == GRANT_RD) begin
            next_state = WR_BURST;
            grant_to   = GRANT_WR;
          end else begin
            next_state = RD_BURST;
            grant_to   = GRANT_RD;
          end
        end else if (wr_valid) begin
          next_state  = WR_BURST;
          grant_start = 1'b1;
          grant_to    = GRANT_WR;
        end else if (rd_valid) begin
          next_state  = RD_BURST;
          grant_start = 1'b1;
          grant_to    = GRANT_RD;
        end
      end
      WR_BURST, RD_BURST: begin
        if (trk_end) begin
          next_state = GAP;
        end
      end
      GAP: begin
        next_state = IDLE;
      end
      REFRESH_WAIT: begin
        if (!guard) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    grant_row = row_of((grant_to == GRANT_WR) ? wr_addr : rd_addr);
  end

  // Handshakes and controller beat fields from the granted requester
  always_comb begin
    wr_ready  = in_wr & trk_ready;
    rd_ready  = in_rd & trk_ready;
    write     = beat_valid & trk_ready;
    keepOpen  = (in_wr | in_rd) & ~guard;
    isWrite   = in_wr;
    address   = beat_addr;
    writeMask = in_wr ? wr_mask : (in_rd ? 2'b11 : 2'b00);
    writeData = in_wr ? wr_data : '0;
  end

  // Read return passes straight through, held at zero during reset
  always_comb begin
    rd_data       = reset_n ? ctrl_readData : '0;
    rd_data_valid = reset_n & ctrl_readValid;
  end

`ifdef SDRAM_ARB_STATS_EN
  // Saturating beat and refresh-stall counters
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_beats       <= '0;
      stat_rd_beats       <= '0;
      stat_refresh_stalls <= '0;
    end else begin
      if (write && in_wr && !(&stat_wr_beats)) begin
        stat_wr_beats <= stat_wr_beats + 32'd1;
      end
      if (write && in_rd && !(&stat_rd_beats)) begin
        stat_rd_beats <= stat_rd_beats + 32'd1;
      end
      if ((state == REFRESH_WAIT) && !(&stat_refresh_stalls)) begin
        stat_refresh_stalls <= stat_refresh_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Directed self-checking bench for sdram_port_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;

  logic        ram_clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        rd_valid, rd_ready;
  logic [24:0] rd_addr;
  logic        rd_urgent;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        ctrl_busy;
  logic [15:0] ctrl_readData;
  logic        ctrl_readValid;
  logic [9:0]  refreshCountdown;
  logic        write, isWrite, keepOpen;
  logic [24:0] address;
  logic [1:0]  writeMask;
  logic [15:0] writeData;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] stat_wr_beats, stat_rd_beats, stat_refresh_stalls;
`endif

  int checks = 0;
  int errors = 0;
  int sent, ws, rs;
  logic exp_w;

  always #5 ram_clk = ~ram_clk;

  sdram_port_arbiter #(
    .DATA_W(16), .BURST_LEN(64), .REFRESH_GUARD(100)
  ) dut (
    .ram_clk(ram_clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_urgent(rd_urgent), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .ctrl_busy(ctrl_busy), .ctrl_readData(ctrl_readData),
    .ctrl_readValid(ctrl_readValid), .refreshCountdown(refreshCountdown),
    .write(write), .isWrite(isWrite), .address(address),
    .writeMask(writeMask), .writeData(writeData), .keepOpen(keepOpen)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats),
    .stat_refresh_stalls(stat_refresh_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // inputs change 2 time units after the rising edge, outputs sampled 1 later
  task automatic tick();
    @(posedge ram_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [24:0] mk_addr(input int row, input int col);
    return {15'(row), 10'(col)};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      rd_urgent = 1'b0;
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; rd_urgent = 1'b0;
    wr_addr = mk_addr(3, 0); rd_addr = mk_addr(2, 0); wr_data = 16'h1234; wr_mask = 2'b01;
    ctrl_busy = 1'b0; ctrl_readData = 16'hA5A5; ctrl_readValid = 1'b1;
    refreshCountdown = 10'd500;
    tick(); tick(); settle();
    check("rst_write", write, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_keep", keepOpen, 0);
    check("rst_address", address, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_data_valid", rd_data_valid, 0);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0; ctrl_readValid = 1'b0;
    reset_n = 1'b1;
    settle();
    check("post_rst_wr_ready", wr_ready, 0);

    // ---------------- writer only, 70 same-row beats ----------------
    sent = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      wr_valid = (sent < 70);
      wr_addr  = mk_addr(3, sent);
      wr_data  = 16'(sent + 256);
      wr_mask  = 2'b01;
      settle();
      exp_w = ((c >= 1) && (c <= 64)) || ((c >= 67) && (c <= 72));
      check("t2_write", write, exp_w);
      check("t2_keepopen", keepOpen, exp_w || (c == 73));
      if (write) begin
        check("t2_isWrite", isWrite, 1);
        check("t2_address", address, mk_addr(3, sent));
        check("t2_writeData", writeData, 32'(sent + 256));
        check("t2_writeMask", writeMask, 2'b01);
        sent++;
      end
    end
    check("t2_total_beats", sent, 70);

    // ---------------- row crossing 5/1023 -> 6/0 ----------------
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      wr_valid = (sent < 3);
      case (sent)
        0:       wr_addr = mk_addr(5, 1023);
        1:       wr_addr = mk_addr(6, 0);
        default: wr_addr = mk_addr(6, 1);
      endcase
      settle();
      exp_w = (c == 1) || (c == 5) || (c == 6);
      check("t3_write", write, exp_w);
      if (c == 2) check("t3_ready_mismatch", wr_ready, 0);
      if (c == 5) check("t3_row6_address", address, mk_addr(6, 0));
      if (write) sent++;
    end
    check("t3_total_beats", sent, 3);

    // ---------------- alternation after a fresh reset ----------------
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    ws = 0; rs = 0;
    for (int c = 0; c < 134; c++) begin
      tick();
      wr_valid = 1'b1; rd_valid = 1'b1; rd_urgent = 1'b0;
      wr_addr = mk_addr(1, ws);
      rd_addr = mk_addr(2, rs);
      settle();
      exp_w = ((c >= 1) && (c <= 64)) || ((c >= 67) && (c <= 130)) || (c == 133);
      check("t4_write", write, exp_w);
      check("t4_isWrite", isWrite, ((c >= 1) && (c <= 64)) || (c == 133));
      check("t4_rd_ready", rd_ready, (c >= 67) && (c <= 130));
      if (write && !isWrite) check("t4_rd_mask", writeMask, 2'b11);
      if (write) begin
        if (isWrite) ws++;
        else rs++;
      end
    end
    check("t4_wr_beats", ws, 65);
    check("t4_rd_beats", rs, 64);
    idle_cycles(4);

    // ---------------- urgent read beats fairness ----------------
    tick(); rd_valid = 1'b1; rd_addr = mk_addr(4, 0); settle();
    check("t5_idle_write", write, 0);
    tick(); settle();
    check("t5_rd_write", write, 1);
    check("t5_rd_isWrite", isWrite, 0);
    check("t5_rd_mask", writeMask, 2'b11);
    check("t5_rd_address", address, mk_addr(4, 0));
    tick(); rd_valid = 1'b0; settle();
    check("t5_rd_drop", write, 0);
    tick();
    tick(); wr_valid = 1'b1; wr_addr = mk_addr(8, 0);
    rd_valid = 1'b1; rd_urgent = 1'b1; rd_addr = mk_addr(4, 1); settle();
    check("t5_idle2_write", write, 0);
    tick(); settle();
    check("t5_urgent_rd_ready", rd_ready, 1);
    check("t5_urgent_wr_ready", wr_ready, 0);
    check("t5_urgent_isWrite", isWrite, 0);
    check("t5_urgent_address", address, mk_addr(4, 1));
    ctrl_readData = 16'hBEEF; ctrl_readValid = 1'b1; settle();
    check("t5_rd_data", rd_data, 16'hBEEF);
    check("t5_rd_data_valid", rd_data_valid, 1);
    ctrl_readValid = 1'b0; settle();
    check("t5_rd_data_valid_low", rd_data_valid, 0);
    idle_cycles(4);

    // ---------------- refresh guard mid-burst ----------------
    sent = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      wr_valid = 1'b1;
      wr_addr  = mk_addr(7, sent);
      refreshCountdown = ((c >= 3) && (c <= 7)) ? 10'd100 : 10'd101;
      settle();
      exp_w = (c == 1) || (c == 2) || (c == 10);
      check("t6_write", write, exp_w);
      check("t6_wr_ready", wr_ready, exp_w);
      check("t6_keepopen", keepOpen, exp_w);
      if (write) sent++;
    end
    check("t6_total_beats", sent, 3);
    refreshCountdown = 10'd500;
    idle_cycles(4);

    // ---------------- busy stall, then reset mid-burst ----------------
    tick(); wr_valid = 1'b1; wr_addr = mk_addr(9, 0); settle();
    tick(); settle();
    check("t7_first_beat", write, 1);
    tick(); ctrl_busy = 1'b1; wr_addr = mk_addr(9, 1); settle();
    check("t7_busy_write", write, 0);
    check("t7_busy_ready", wr_ready, 0);
    check("t7_busy_keepopen", keepOpen, 1);
    tick(); ctrl_busy = 1'b0; settle();
    check("t7_resume_write", write, 1);
    tick(); ctrl_busy = 1'b1; wr_addr = mk_addr(9, 2); reset_n = 1'b0; settle();
    check("t7_rst_write", write, 0);
    check("t7_rst_wr_ready", wr_ready, 0);
    check("t7_rst_keepopen", keepOpen, 0);
    check("t7_rst_isWrite", isWrite, 0);
    check("t7_rst_address", address, 0);
    tick(); ctrl_busy = 1'b0; settle();
    check("t7_rst_hold_write", write, 0);
    tick(); reset_n = 1'b1; rd_valid = 1'b1; rd_addr = mk_addr(2, 0); settle();
    check("t7_idle_wr_ready", wr_ready, 0);
    check("t7_idle_rd_ready", rd_ready, 0);
    tick(); settle();
    check("t7_contest_wr_ready", wr_ready, 1);
    check("t7_contest_rd_ready", rd_ready, 0);
    check("t7_contest_write", write, 1);
    check("t7_contest_isWrite", isWrite, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
